// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, width helper and adjust-mode type for the
// run-time adjustable VGA timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 32'd640;
    localparam int DEF_H_FP       = 32'd16;
    localparam int DEF_H_SYNC     = 32'd96;
    localparam int DEF_H_BP       = 32'd48;
    localparam int DEF_V_ACTIVE   = 32'd480;
    localparam int DEF_V_FP       = 32'd10;
    localparam int DEF_V_SYNC     = 32'd2;
    localparam int DEF_V_BP       = 32'd33;
    localparam int DEF_DEB_CYCLES = 32'd250000;

    // Smallest width able to hold 0..value-1, never narrower than one bit.
    function automatic int clog2w(input int value);
        int w;
        w = 32'd1;
        for (int i = 32'd1; i < 32'd31; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 32'd1;
            end
        end
        return w;
    endfunction

    typedef enum logic {
        ADJ_H = 1'b0,
        ADJ_V = 1'b1
    } adj_mode_t;

endpackage

// File: rtl/vga_timing_adj_if.sv
// Key inputs and raster/status outputs of the adjustable VGA timing generator.
interface vga_timing_adj_if #(
    parameter int XW = 32'd10,
    parameter int YW = 32'd10
);
    logic [2:0]    key;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          frame_start;
    logic          adj_mode;
    logic [XW-1:0] h_off;
    logic [YW-1:0] v_off;

    modport master (
        input  key,
        output hsync, vsync, video_on, pixel_x, pixel_y, frame_start,
        output adj_mode, h_off, v_off
    );

    modport slave (
        output key,
        input  hsync, vsync, video_on, pixel_x, pixel_y, frame_start,
        input  adj_mode, h_off, v_off
    );
endinterface

// File: rtl/vga_timing_adj_key_debounce.sv
// Two-flop synchroniser plus counter debouncer for one key; emits a single
// press pulse on each accepted released->pressed transition.
module key_debounce
    import vga_timing_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic level,
    output logic press
);
    localparam int             CW       = clog2w(DEB_CYCLES);
    localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CYCLES - 32'd1);
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          press_r;
    logic          pressed_s;

    assign pressed_s = sync_r[1] ^ ACTIVE_LOW;

    // Bring the asynchronous pin into the clock domain, idling at the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {2{ACTIVE_LOW}};
        end else begin
            sync_r <= {sync_r[0], key_in};
        end
    end

    // Accept a new level only after it has persisted for DEB_CYCLES clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (pressed_s == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == DEB_LAST) begin
                cnt_r   <= '0;
                level_r <= pressed_s;
                press_r <= pressed_s;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign level = level_r;
    assign press = press_r;
endmodule

// File: rtl/vga_timing_adj.sv
// Generic VGA sync generator whose visible window can be moved inside the
// porch budget by three debounced keys; offsets change only at frame boundaries.
module vga_timing_adj
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE       = DEF_H_ACTIVE,
    parameter int H_FP           = DEF_H_FP,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BP           = DEF_H_BP,
    parameter int V_ACTIVE       = DEF_V_ACTIVE,
    parameter int V_FP           = DEF_V_FP,
    parameter int V_SYNC         = DEF_V_SYNC,
    parameter int V_BP           = DEF_V_BP,
    parameter bit HS_POL         = 1'b0,
    parameter bit VS_POL         = 1'b0,
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_adj_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = clog2w(H_TOTAL);
    localparam int YW      = clog2w(V_TOTAL);

    localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 32'd1);
    localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 32'd1);
    localparam logic [XW-1:0] H_SYNC_W  = XW'(H_SYNC);
    localparam logic [YW-1:0] V_SYNC_W  = YW'(V_SYNC);
    localparam logic [XW-1:0] H_BP_W    = XW'(H_BP);
    localparam logic [YW-1:0] V_BP_W    = YW'(V_BP);
    localparam logic [XW-1:0] H_OFF_MAX = XW'(H_BP + H_FP);
    localparam logic [YW-1:0] V_OFF_MAX = YW'(V_BP + V_FP);
    localparam logic [XW:0]   H_ACT_X   = (XW+1)'(H_ACTIVE);
    localparam logic [YW:0]   V_ACT_X   = (YW+1)'(V_ACTIVE);
    localparam logic [XW-1:0] X_ONE     = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [YW-1:0] Y_ONE     = {{(YW-1){1'b0}}, 1'b1};

    logic [XW-1:0] h_cnt_r, h_off_r, pend_h_r, pend_h_nxt_s, px_s;
    logic [YW-1:0] v_cnt_r, v_off_r, pend_v_r, pend_v_nxt_s, py_s;
    logic [XW:0]   h_start_s, h_end_s;
    logic [YW:0]   v_start_s, v_end_s;
    logic          h_last_s, v_last_s, h_win_s, v_win_s;
    logic          step_up_s, step_dn_s;
    logic [2:0]    key_level_s, key_press_s, key_event_s;
    adj_mode_t     mode_r;
    logic          hsync_r, vsync_r, video_on_r, frame_start_r;
    logic [XW-1:0] pixel_x_r;
    logic [YW-1:0] pixel_y_r;

    for (genvar i = 32'd0; i < 32'd3; i++) begin : g_key
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .key_in (bus.key[i]),
            .level  (key_level_s[i]),
            .press  (key_press_s[i])
        );
    end

    assign key_event_s = key_press_s & key_level_s;
    assign h_last_s    = (h_cnt_r == H_LAST);
    assign v_last_s    = (v_cnt_r == V_LAST);

    // Raster counters: the line counter advances on each pixel-counter wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (h_last_s) begin
            h_cnt_r <= '0;
            v_cnt_r <= v_last_s ? '0 : v_cnt_r + Y_ONE;
        end else begin
            h_cnt_r <= h_cnt_r + X_ONE;
        end
    end

    // Visible window sits right after sync plus the committed back porch.
    always_comb begin
        h_start_s = {1'b0, H_SYNC_W} + {1'b0, h_off_r};
        h_end_s   = h_start_s + H_ACT_X;
        v_start_s = {1'b0, V_SYNC_W} + {1'b0, v_off_r};
        v_end_s   = v_start_s + V_ACT_X;
        h_win_s   = ({1'b0, h_cnt_r} >= h_start_s) && ({1'b0, h_cnt_r} < h_end_s);
        v_win_s   = ({1'b0, v_cnt_r} >= v_start_s) && ({1'b0, v_cnt_r} < v_end_s);
        px_s      = h_cnt_r - h_start_s[XW-1:0];
        py_s      = v_cnt_r - v_start_s[YW-1:0];
    end

    // Raster outputs, all one clock behind the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_r       <= ~HS_POL;
            vsync_r       <= ~VS_POL;
            video_on_r    <= 1'b0;
            pixel_x_r     <= '0;
            pixel_y_r     <= '0;
            frame_start_r <= 1'b0;
        end else begin
            hsync_r       <= (h_cnt_r < H_SYNC_W) ? HS_POL : ~HS_POL;
            vsync_r       <= (v_cnt_r < V_SYNC_W) ? VS_POL : ~VS_POL;
            video_on_r    <= h_win_s & v_win_s;
            pixel_x_r     <= (h_win_s & v_win_s) ? px_s : '0;
            pixel_y_r     <= (h_win_s & v_win_s) ? py_s : '0;
            frame_start_r <= (h_cnt_r == '0) && (v_cnt_r == '0);
        end
    end

    // Simultaneous inc and dec cancel; the step goes to the mode before any toggle.
    always_comb begin
        step_up_s    = key_event_s[2] & ~key_event_s[1];
        step_dn_s    = key_event_s[1] & ~key_event_s[2];
        pend_h_nxt_s = pend_h_r;
        pend_v_nxt_s = pend_v_r;
        if (mode_r == ADJ_H) begin
            if (step_up_s && (pend_h_r != H_OFF_MAX)) begin
                pend_h_nxt_s = pend_h_r + X_ONE;
            end else if (step_dn_s && (pend_h_r != '0)) begin
                pend_h_nxt_s = pend_h_r - X_ONE;
            end else begin
                pend_h_nxt_s = pend_h_r;
            end
        end else begin
            if (step_up_s && (pend_v_r != V_OFF_MAX)) begin
                pend_v_nxt_s = pend_v_r + Y_ONE;
            end else if (step_dn_s && (pend_v_r != '0)) begin
                pend_v_nxt_s = pend_v_r - Y_ONE;
            end else begin
                pend_v_nxt_s = pend_v_r;
            end
        end
    end

    // Pending offsets track key presses; committed offsets load on the last clock of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= ADJ_H;
            pend_h_r <= H_BP_W;
            pend_v_r <= V_BP_W;
            h_off_r  <= H_BP_W;
            v_off_r  <= V_BP_W;
        end else begin
            pend_h_r <= pend_h_nxt_s;
            pend_v_r <= pend_v_nxt_s;
            if (key_event_s[0]) begin
                mode_r <= (mode_r == ADJ_H) ? ADJ_V : ADJ_H;
            end
            if (h_last_s && v_last_s) begin
                h_off_r <= pend_h_r;
                v_off_r <= pend_v_r;
            end
        end
    end

    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.video_on    = video_on_r;
    assign bus.pixel_x     = pixel_x_r;
    assign bus.pixel_y     = pixel_y_r;
    assign bus.frame_start = frame_start_r;
    assign bus.adj_mode    = (mode_r == ADJ_V);
    assign bus.h_off       = h_off_r;
    assign bus.v_off       = v_off_r;
endmodule

// File: tb/tb_vga_timing_adj.sv
// Randomised self-checking bench: a frame-level raster model predicts every
// output cycle by cycle on a reduced timing so several frames run quickly.
module tb_vga_timing_adj;
    import vga_timing_pkg::*;

    localparam int H_ACTIVE = 16, H_FP = 4, H_SYNC = 6, H_BP = 5;
    localparam int V_ACTIVE = 10, V_FP = 3, V_SYNC = 2, V_BP = 4;
    localparam int H_T   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_T   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_T * V_T;
    localparam int XW    = clog2w(H_T);
    localparam int YW    = clog2w(V_T);
    localparam int H_MAX = H_BP + H_FP;
    localparam int V_MAX = V_BP + V_FP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key = 3'b111;

    int checks = 0;
    int errors = 0;
    int m_h, m_v, m_offh, m_offv, m_pendh, m_pendv, m_mode;

    always #5 clk = ~clk;

    vga_timing_adj_if #(.XW(XW), .YW(YW)) bus0 ();
    vga_timing_adj_if #(.XW(XW), .YW(YW)) bus1 ();
    assign bus0.key = key;
    assign bus1.key = key;

    vga_timing_adj #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .DEB_CYCLES(4), .KEY_ACTIVE_LOW(1'b1)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    vga_timing_adj #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .DEB_CYCLES(4), .KEY_ACTIVE_LOW(1'b1)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int clamp(input int val, input int hi);
        return (val < 0) ? 0 : ((val > hi) ? hi : val);
    endfunction

    // Raster model: m_h/m_v/m_off* describe the cycle whose outputs appear now.
    initial begin
        int hst, vst;
        bit hw, vw, vid;
        forever begin
            @(negedge clk);
            if (rst) begin
                check_val("rst_hsync0", bus0.hsync, 1);
                check_val("rst_vsync0", bus0.vsync, 1);
                check_val("rst_hsync1", bus1.hsync, 0);
                check_val("rst_vsync1", bus1.vsync, 0);
                check_val("rst_video", bus0.video_on, 0);
                check_val("rst_px", bus0.pixel_x, 0);
                check_val("rst_py", bus0.pixel_y, 0);
                check_val("rst_fs", bus0.frame_start, 0);
                check_val("rst_mode", bus0.adj_mode, 0);
                check_val("rst_h_off", bus0.h_off, H_BP);
                check_val("rst_v_off", bus0.v_off, V_BP);
                m_h = 0; m_v = 0; m_mode = 0;
                m_offh = H_BP; m_offv = V_BP; m_pendh = H_BP; m_pendv = V_BP;
            end else begin
                hst = H_SYNC + m_offh;
                vst = V_SYNC + m_offv;
                hw  = (m_h >= hst) && (m_h < hst + H_ACTIVE);
                vw  = (m_v >= vst) && (m_v < vst + V_ACTIVE);
                vid = hw && vw;
                check_val("hsync0", bus0.hsync, (m_h < H_SYNC) ? 0 : 1);
                check_val("vsync0", bus0.vsync, (m_v < V_SYNC) ? 0 : 1);
                check_val("hsync1", bus1.hsync, (m_h < H_SYNC) ? 1 : 0);
                check_val("vsync1", bus1.vsync, (m_v < V_SYNC) ? 1 : 0);
                check_val("video_on", bus0.video_on, vid);
                check_val("pixel_x", bus0.pixel_x, vid ? m_h - hst : 0);
                check_val("pixel_y", bus0.pixel_y, vid ? m_v - vst : 0);
                check_val("frame_start", bus0.frame_start, (m_h == 0 && m_v == 0));
                if (m_h == H_T - 1 && m_v == V_T - 1) begin
                    m_offh = m_pendh;
                    m_offv = m_pendv;
                end
                if (m_h == H_T - 1) begin
                    m_h = 0;
                    m_v = (m_v == V_T - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
                check_val("h_off", bus0.h_off, m_offh);
                check_val("v_off", bus0.v_off, m_offv);
            end
        end
    end

    task automatic wait_frame();
        int n = 0;
        @(negedge clk);
        while (!(m_v == 0 && m_h < 2) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME) check_val("wait_frame_timeout", 0, 1);
    endtask

    task automatic model_apply(input logic [2:0] mask);
        int d = 0;
        if (mask[2] && !mask[1]) d = 1;
        else if (mask[1] && !mask[2]) d = -1;
        if (m_mode == 0) m_pendh = clamp(m_pendh + d, H_MAX);
        else             m_pendv = clamp(m_pendv + d, V_MAX);
        if (mask[0]) m_mode = 1 - m_mode;
    endtask

    // One clean press of the keys in mask, kept well clear of the frame commit.
    task automatic press(input logic [2:0] mask);
        if (m_v * H_T + m_h > FRAME - 60) wait_frame();
        @(negedge clk);
        key = ~mask;
        repeat (8) @(negedge clk);
        key = 3'b111;
        repeat (8) @(negedge clk);
        model_apply(mask);
        check_val("adj_mode", bus0.adj_mode, m_mode);
    endtask

    task automatic glitch(input logic [2:0] mask, input int len, input int reps);
        for (int i = 0; i < reps; i++) begin
            @(negedge clk);
            key = ~mask;
            repeat (len) @(negedge clk);
            key = 3'b111;
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int hs_cnt, vs_cnt, vid_cnt, hs1_cnt, n;
        logic [2:0] masks [7];
        masks = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b101, 3'b011, 3'b111};

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        hs_cnt = 0; vs_cnt = 0; vid_cnt = 0; hs1_cnt = 0;
        repeat (FRAME) begin
            @(negedge clk);
            hs_cnt  += (bus0.hsync == 1'b0);
            vs_cnt  += (bus0.vsync == 1'b0);
            vid_cnt += bus0.video_on;
            hs1_cnt += bus1.hsync;
        end
        check_val("hsync_low_per_frame", hs_cnt, H_SYNC * V_T);
        check_val("vsync_low_per_frame", vs_cnt, V_SYNC * H_T);
        check_val("video_per_frame", vid_cnt, H_ACTIVE * V_ACTIVE);
        check_val("hsync1_high_per_frame", hs1_cnt, H_SYNC * V_T);
        wait_frame();

        wait_frame();
        press(3'b100);
        check_val("h_off_before_commit", bus0.h_off, H_BP);
        wait_frame();
        check_val("h_off_inc", bus0.h_off, H_BP + 1);

        glitch(3'b100, 2, 10);
        glitch(3'b100, 3, 10);
        wait_frame();
        check_val("h_off_glitch", bus0.h_off, H_BP + 1);
        repeat (8) press(3'b100);
        wait_frame();
        check_val("h_off_clamp_hi", bus0.h_off, H_MAX);
        repeat (12) press(3'b010);
        wait_frame();
        check_val("h_off_clamp_lo", bus0.h_off, 0);

        press(3'b001);
        check_val("mode_v", bus0.adj_mode, 1);
        repeat (3) press(3'b010);
        wait_frame();
        check_val("v_off_dec", bus0.v_off, V_BP - 3);
        check_val("h_off_untouched", bus0.h_off, 0);

        press(3'b110);
        wait_frame();
        check_val("v_off_cancel", bus0.v_off, V_BP - 3);
        wait_frame();
        repeat (3) press(3'b100);
        check_val("v_off_mid_frame", bus0.v_off, V_BP - 3);
        wait_frame();
        check_val("v_off_single_commit", bus0.v_off, V_BP);
        press(3'b101);
        check_val("mode_back_h", bus0.adj_mode, 0);
        wait_frame();
        check_val("v_off_old_mode", bus0.v_off, V_BP + 1);

        for (int i = 0; i < 40; i++) begin
            press(masks[$urandom_range(0, 6)]);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_frame();
        wait_frame();

        n = 0;
        while (m_h != 15 && n < 2 * H_T) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_hsync1", bus1.hsync, 0);
        check_val("mid_rst_vsync1", bus1.vsync, 0);
        check_val("mid_rst_hsync0", bus0.hsync, 1);
        check_val("mid_rst_video", bus0.video_on, 0);
        check_val("mid_rst_h_off", bus0.h_off, H_BP);
        check_val("mid_rst_v_off", bus0.v_off, V_BP);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("first_frame_start", bus0.frame_start, 1);
        @(negedge clk);
        check_val("frame_start_pulse", bus0.frame_start, 0);
        wait_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
